// File: rtl/vending_coin_feeder.sv
// rtl/vending_coin_feeder.sv - coin sensor front end feeding and checking the vending controller
module vending_coin_feeder #(
   parameter int DEPTH = 4,
   parameter int GAP   = 1,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    nickel_in,
   input  logic                    dime_in,
   input  logic                    hold,
   input  logic                    dispense,
   input  logic                    chg5,
   output logic [1:0]              coin,
   output logic                    busy,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    reject,
   output logic                    err,
   output logic [CNT_W-1:0]        vend_cnt,
   output logic [CNT_W-1:0]        chg_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // sensor history, set after reset so a level already high is not an edge
   logic             hist_n_q, hist_n_d;
   logic             hist_d_q, hist_d_d;

   // coin FIFO
   logic [1:0]       fifo_q [DEPTH];
   logic [1:0]       fifo_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;

   // issue FSM
   state_t           state_q, state_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [1:0]       coin_q, coin_d;

   // status and shadow credit model (credit is in money units, always < 20)
   logic             reject_q, reject_d;
   logic             err_q, err_d;
   logic [4:0]       credit_q, credit_d;
   logic [CNT_W-1:0] vend_q, vend_d;
   logic [CNT_W-1:0] chg_q, chg_d;

   logic             ev_n, ev_d;
   logic             push, pop;
   logic [1:0]       push_code;
   logic             full_w, empty_w;
   logic [1:0]       head;
   logic [4:0]       total;
   logic             exp_disp, exp_chg;

   assign full_w  = (count_q == FULL_LVL);
   assign empty_w = (count_q == '0);
   assign head    = fifo_q[rd_ptr_q];

   // edge detection, jam/overflow rejection and FIFO bookkeeping
   always_comb begin
      hist_n_d  = nickel_in;
      hist_d_d  = dime_in;
      ev_n      = nickel_in & ~hist_n_q;
      ev_d      = dime_in & ~hist_d_q;
      push_code = ev_n ? 2'b01 : 2'b10;
      push      = (ev_n ^ ev_d) & ~full_w;
      reject_d  = (ev_n & ev_d) | ((ev_n ^ ev_d) & full_w);
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = push_code;
         wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   // issue FSM next state; a coin may be popped straight out of the last gap cycle
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      coin_d    = 2'b00;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_w && !hold) begin
               pop     = 1'b1;
               coin_d  = head;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (!empty_w && !hold) begin
                  pop     = 1'b1;
                  coin_d  = head;
                  state_d = S_DRIVE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // shadow credit check of the controller's Mealy response at the end of each drive
   always_comb begin
      err_d    = err_q;
      credit_d = credit_q;
      vend_d   = vend_q;
      chg_d    = chg_q;
      total    = credit_q + ((coin_q == 2'b01) ? 5'd5 : 5'd10);
      exp_disp = (total >= 5'd20);
      exp_chg  = (total == 5'd25);
      if (state_q == S_DRIVE) begin
         if ((dispense != exp_disp) || (chg5 != exp_chg)) begin
            err_d = 1'b1;
         end
         credit_d = exp_disp ? 5'd0 : total;
         if (dispense) begin
            vend_d = vend_q + CNT_W'(1);
         end
         if (chg5) begin
            chg_d = chg_q + CNT_W'(1);
         end
      end else if (dispense || chg5) begin
         err_d = 1'b1;
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_n_q  <= 1'b1;
         hist_d_q  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= 2'b00;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= S_IDLE;
         gap_cnt_q <= '0;
         coin_q    <= 2'b00;
         reject_q  <= 1'b0;
         err_q     <= 1'b0;
         credit_q  <= '0;
         vend_q    <= '0;
         chg_q     <= '0;
      end else begin
         hist_n_q  <= hist_n_d;
         hist_d_q  <= hist_d_d;
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         coin_q    <= coin_d;
         reject_q  <= reject_d;
         err_q     <= err_d;
         credit_q  <= credit_d;
         vend_q    <= vend_d;
         chg_q     <= chg_d;
      end
   end

   assign coin     = coin_q;
   assign busy     = (state_q != S_IDLE) | ~empty_w;
   assign full     = full_w;
   assign level    = count_q;
   assign reject   = reject_q;
   assign err      = err_q;
   assign vend_cnt = vend_q;
   assign chg_cnt  = chg_q;

endmodule

// File: tb/tb_vending_coin_feeder.sv
// tb/tb_vending_coin_feeder.sv - scoreboard bench for vending_coin_feeder
module tb_vending_coin_feeder;

   localparam int DEPTH = 4;
   localparam int GAP   = 1;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             nickel_in, dime_in, hold;
   logic             dispense, chg5;
   logic [1:0]       coin;
   logic             busy, full, reject, err;
   logic [2:0]       level;
   logic [CNT_W-1:0] vend_cnt, chg_cnt;

   vending_coin_feeder #(.DEPTH(DEPTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .nickel_in(nickel_in), .dime_in(dime_in), .hold(hold),
      .dispense(dispense), .chg5(chg5), .coin(coin), .busy(busy), .full(full),
      .level(level), .reject(reject), .err(err), .vend_cnt(vend_cnt), .chg_cnt(chg_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural vending controller: Mealy response to the coin bus
   logic       force_disp;
   int         ctrl_credit;
   int         coin_val;
   int         exp_vend, exp_chg;
   logic       exp_err;

   always_comb begin
      coin_val = (coin == 2'b01) ? 5 : ((coin == 2'b10) ? 10 : 0);
      dispense = ((coin_val != 0) && (ctrl_credit + coin_val >= 20)) || force_disp;
      chg5     = (coin_val != 0) && (ctrl_credit + coin_val == 25);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_credit <= 0;
         exp_vend    <= 0;
         exp_chg     <= 0;
         exp_err     <= 1'b0;
      end else begin
         if (coin_val != 0) begin
            if (ctrl_credit + coin_val >= 20) begin
               ctrl_credit <= 0;
               exp_vend    <= (exp_vend + 1) % 256;
               if (ctrl_credit + coin_val == 25) exp_chg <= (exp_chg + 1) % 256;
            end else begin
               ctrl_credit <= ctrl_credit + coin_val;
            end
         end
         if (force_disp && coin_val == 0) exp_err <= 1'b1;
      end
   end

   // inputs as seen at each rising edge
   logic s_n, s_d, s_h, s_rst;
   always @(posedge clk) begin
      s_n   <= nickel_in;
      s_d   <= dime_in;
      s_h   <= hold;
      s_rst <= rst;
   end

   // scoreboard monitor: expected coins queued on sensor edges, popped when a coin appears
   logic [1:0] mq[$];
   initial begin
      logic ph_n, ph_d, ev_n, ev_d, prev_nz, exp_rej;
      int   sz, idle;
      ph_n = 1'b1; ph_d = 1'b1; prev_nz = 1'b0; idle = GAP;
      forever begin
         @(negedge clk);
         if (!rst || !s_rst) begin
            mq.delete();
            ph_n = 1'b1; ph_d = 1'b1; prev_nz = 1'b0; idle = GAP;
         end else begin
            ev_n = s_n && !ph_n;
            ev_d = s_d && !ph_d;
            ph_n = s_n;
            ph_d = s_d;
            sz   = mq.size();
            exp_rej = 1'b0;
            if (coin != 2'b00) begin
               chk("coin_while_hold", int'(s_h), 0);
               chk("drive_one_cycle", int'(prev_nz), 0);
               chk("gap_spacing", int'(idle >= GAP), 1);
               chk("busy_in_drive", int'(busy), 1);
               if (sz == 0) chk("coin_unexpected", int'(coin), 0);
               else chk("coin_code", int'(coin), int'(mq.pop_front()));
               prev_nz = 1'b1;
               idle    = 0;
            end else begin
               prev_nz = 1'b0;
               if (idle < 1000) idle++;
            end
            if (ev_n && ev_d) exp_rej = 1'b1;
            else if (ev_n || ev_d) begin
               if (sz == DEPTH) exp_rej = 1'b1;
               else mq.push_back(ev_n ? 2'b01 : 2'b10);
            end
            chk("reject", int'(reject), int'(exp_rej));
            chk("level", int'(level), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            if (mq.size() != 0) chk("busy_fifo", int'(busy), 1);
            chk("err", int'(err), int'(exp_err));
            chk("vend_cnt", int'(vend_cnt), exp_vend);
            chk("chg_cnt", int'(chg_cnt), exp_chg);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic n, input logic d);
      nickel_in = n;
      dime_in   = d;
      tick();
      nickel_in = 1'b0;
      dime_in   = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || mq.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_timeout", int'(busy), 0);
      tick();
   endtask

   task automatic wait_coin();
      int n = 0;
      @(negedge clk);
      while (coin == 2'b00 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("coin_timeout", int'(coin != 2'b00), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; nickel_in = 1'b0; dime_in = 1'b0; hold = 1'b0; force_disp = 1'b0;
      #3;
      chk("rst_coin", int'(coin), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_vend", int'(vend_cnt), 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // two dimes
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      wait_idle();
      chk("t1_vend", int'(vend_cnt), 1);
      chk("t1_chg", int'(chg_cnt), 0);

      // nickel nickel dime
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      wait_idle();
      chk("t2_vend", int'(vend_cnt), 2);

      // nickel dime dime -> change
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      wait_idle();
      chk("t3_vend", int'(vend_cnt), 3);
      chk("t3_chg", int'(chg_cnt), 1);

      // hold fills FIFO, fifth nickel overflows
      hold = 1'b1;
      for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
      chk("t4_level", int'(level), 4);
      chk("t4_full", int'(full), 1);
      pulse(1'b1, 1'b0);
      chk("t4_level_after", int'(level), 4);
      hold = 1'b0;
      wait_idle();
      chk("t4_vend", int'(vend_cnt), 4);

      // jam
      pulse(1'b1, 1'b1);
      chk("t5_level", int'(level), 0);
      chk("t5_coin", int'(coin), 0);

      // spurious dispense during gap
      pulse(1'b0, 1'b1);
      wait_coin();
      @(posedge clk); #1;
      force_disp = 1'b1;
      tick();
      force_disp = 1'b0;
      tick();
      chk("t6_err_set", int'(err), 1);
      wait_idle();
      chk("t6_err_sticky", int'(err), 1);

      // reset in the middle of a drive
      pulse(1'b0, 1'b1);
      wait_coin();
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_coin", int'(coin), 0);
      chk("t6_rst_level", int'(level), 0);
      chk("t6_rst_err", int'(err), 0);
      chk("t6_rst_vend", int'(vend_cnt), 0);
      chk("t6_rst_chg", int'(chg_cnt), 0);
      tick();
      rst = 1'b1;
      tick();

      // dime held through reset release
      dime_in = 1'b1;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      dime_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t6_held_level", int'(level), 0);
      chk("t6_held_coin", int'(coin), 0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         nickel_in = ($urandom_range(0, 2) == 0);
         dime_in   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) hold = ~hold;
         tick();
      end
      nickel_in = 1'b0;
      dime_in   = 1'b0;
      hold      = 1'b0;
      wait_idle();
      chk("rand_err", int'(err), 0);
      chk("rand_vend", int'(vend_cnt), exp_vend);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
